// File: rtl/vgg16_layer_sequencer_pkg.sv
// Shared constants for the VGG16 run controller: the sequencer state
// encoding, the conv-layer geometry tables and the FC drain length.
package vgg16_layer_sequencer_pkg;

    localparam int NUM_CONV_LAYERS = 13;
    localparam int LAYER_W         = 4;
    localparam int CFG_W           = 8;
    localparam int ADDR_WIDTH      = 32;
    localparam int TIMEOUT_W       = 24;

    // The last FC layer produces FOUT3 outputs, packed AF per result word.
    localparam int FOUT3     = 1000;
    localparam int AF        = 3;
    localparam int RES_WORDS = (FOUT3 + AF - 1) / AF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG,
        ST_CONV_GO,
        ST_CONV_WAIT,
        ST_FC_GO,
        ST_FC_WAIT,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } seq_state_t;

    // Geometry per conv layer. Wh: output channels in groups of 4,
    // Ww: input channels in groups of 4 (rounded up), Iw: input map width.
    localparam logic [CFG_W-1:0] CONV_Wh [NUM_CONV_LAYERS] = '{
        8'd16, 8'd16, 8'd32, 8'd32, 8'd64, 8'd64, 8'd64,
        8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128
    };
    localparam logic [CFG_W-1:0] CONV_Ww [NUM_CONV_LAYERS] = '{
        8'd1, 8'd16, 8'd16, 8'd32, 8'd32, 8'd64, 8'd64,
        8'd64, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128
    };
    localparam logic [CFG_W-1:0] CONV_Iw [NUM_CONV_LAYERS] = '{
        8'd224, 8'd224, 8'd112, 8'd112, 8'd56, 8'd56, 8'd56,
        8'd28, 8'd28, 8'd28, 8'd14, 8'd14, 8'd14
    };

endpackage

// File: rtl/vgg16_layer_sequencer_if.sv
// Bundle of the sequencer's control, engine and result-drain signals.
interface vgg16_layer_sequencer_if;
    import vgg16_layer_sequencer_pkg::*;

    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [LAYER_W-1:0]    conv_layer;
    logic [CFG_W-1:0]      conv_wh;
    logic [CFG_W-1:0]      conv_ww;
    logic [CFG_W-1:0]      conv_iw;
    logic                  conv_start;
    logic                  conv_done;
    logic                  fc_start;
    logic                  fc_done;
    logic [ADDR_WIDTH-1:0] result_rd_addr;
    logic                  result_valid;
    logic                  result_ready;
    logic                  result_word_taken;

    // Result handshake: a word transfers on a rising edge where result_valid
    // and result_ready are both high. The buffer may raise or drop valid at
    // will; ready is high for the whole DRAIN state and nowhere else. After a
    // transfer result_rd_addr moves to the next word and result_word_taken
    // pulses for one cycle.
    modport master (
        input  start, conv_done, fc_done, result_valid,
        output busy, done, error, conv_layer, conv_wh, conv_ww, conv_iw,
               conv_start, fc_start, result_rd_addr, result_ready,
               result_word_taken
    );

    modport slave (
        output start, conv_done, fc_done, result_valid,
        input  busy, done, error, conv_layer, conv_wh, conv_ww, conv_iw,
               conv_start, fc_start, result_rd_addr, result_ready,
               result_word_taken
    );

endinterface

// File: rtl/vgg16_layer_sequencer_seq_watchdog.sv
// Saturating stall counter; expired stays high once the count is all ones.
module seq_watchdog #(
    parameter int W = 24
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] count_q, count_d;

    assign expired = &count_q;

    // Clear wins over counting; counting stops at all ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vgg16_layer_sequencer.sv
// Top-level run controller: steps the conv engine through every layer,
// launches the FC stage, drains the FC result buffer and guards each wait
// phase with a watchdog.
module vgg16_layer_sequencer
    import vgg16_layer_sequencer_pkg::*;
#(
    parameter int N_LAYERS = NUM_CONV_LAYERS,
    parameter int N_WORDS  = RES_WORDS,
    parameter int WDOG_W   = TIMEOUT_W
) (
    input  logic                           clk,
    input  logic                           rstn,
    vgg16_layer_sequencer_if.master        seq_if,
    output seq_state_t                     dbg_state_o
);

    localparam logic [LAYER_W-1:0]    LAST_LAYER = LAYER_W'(N_LAYERS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(N_WORDS - 1);

    seq_state_t            state_q, state_d;
    logic [LAYER_W-1:0]    layer_q, layer_d;
    logic [CFG_W-1:0]      wh_q, wh_d;
    logic [CFG_W-1:0]      ww_q, ww_d;
    logic [CFG_W-1:0]      iw_q, iw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  busy_q, done_q, error_q;
    logic                  conv_start_q, fc_start_q, ready_q, taken_q;
    logic                  take;
    logic                  wd_clr, wd_en, wd_expired;

    // ready_q is high exactly while in DRAIN, so valid outside DRAIN is ignored.
    assign take   = seq_if.result_valid && ready_q;
    assign wd_en  = state_q inside {ST_CONV_WAIT, ST_FC_WAIT, ST_DRAIN};
    assign wd_clr = (state_d != state_q) || take;

    seq_watchdog #(
        .W (WDOG_W)
    ) u_watchdog (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // Next-state, layer, geometry and address logic.
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        wh_d    = wh_q;
        ww_d    = ww_q;
        iw_d    = iw_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (seq_if.start) begin
                    state_d = ST_CFG;
                    layer_d = '0;
                    addr_d  = '0;
                end
            end
            ST_CFG: begin
                state_d = ST_CONV_GO;
                wh_d    = CONV_Wh[layer_q];
                ww_d    = CONV_Ww[layer_q];
                iw_d    = CONV_Iw[layer_q];
            end
            ST_CONV_GO: begin
                state_d = ST_CONV_WAIT;
            end
            ST_CONV_WAIT: begin
                // A completion seen together with expiry still counts.
                if (seq_if.conv_done) begin
                    if (layer_q == LAST_LAYER) begin
                        state_d = ST_FC_GO;
                    end else begin
                        state_d = ST_CFG;
                        layer_d = layer_q + LAYER_W'(1);
                    end
                end else if (wd_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_FC_GO: begin
                state_d = ST_FC_WAIT;
            end
            ST_FC_WAIT: begin
                if (seq_if.fc_done) begin
                    state_d = ST_DRAIN;
                end else if (wd_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_DRAIN: begin
                if (take) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end
                end else if (wd_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; strobes are decoded from the next state
    // so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            layer_q      <= '0;
            wh_q         <= '0;
            ww_q         <= '0;
            iw_q         <= '0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            conv_start_q <= 1'b0;
            fc_start_q   <= 1'b0;
            ready_q      <= 1'b0;
            taken_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            wh_q         <= wh_d;
            ww_q         <= ww_d;
            iw_q         <= iw_d;
            addr_q       <= addr_d;
            busy_q       <= !(state_d inside {ST_IDLE, ST_ERR});
            done_q       <= (state_d == ST_DONE);
            error_q      <= (state_d == ST_ERR);
            conv_start_q <= (state_d == ST_CONV_GO);
            fc_start_q   <= (state_d == ST_FC_GO);
            ready_q      <= (state_d == ST_DRAIN);
            taken_q      <= take;
        end
    end

    assign seq_if.busy              = busy_q;
    assign seq_if.done              = done_q;
    assign seq_if.error             = error_q;
    assign seq_if.conv_layer        = layer_q;
    assign seq_if.conv_wh           = wh_q;
    assign seq_if.conv_ww           = ww_q;
    assign seq_if.conv_iw           = iw_q;
    assign seq_if.conv_start        = conv_start_q;
    assign seq_if.fc_start          = fc_start_q;
    assign seq_if.result_rd_addr    = addr_q;
    assign seq_if.result_ready      = ready_q;
    assign seq_if.result_word_taken = taken_q;
    assign dbg_state_o              = state_q;

endmodule
